// File: rtl/arena_painter.sv
// Row-by-row bulk initialiser for the Conway arena: clear, fill, checkerboard,
// pseudo-random (Galois LFSR) or invert, behind the shared start/ready row-write port set.
module arena_painter #(
  parameter int          ARENA_WIDTH       = 10,
  parameter int          ARENA_HEIGHT      = 10,
  parameter logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [2:0]             mode,
  input  logic [15:0]            seed,
  input  logic [ARENA_WIDTH-1:0] arena_columns_cur,
  output logic                   ready,
  output logic                   done,
  output logic [7:0]             arena_row_select,
  output logic [ARENA_WIDTH-1:0] arena_columns_new,
  output logic                   arena_columns_write,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [2:0] MODE_CLEAR   = 3'd0;
  localparam logic [2:0] MODE_FILL    = 3'd1;
  localparam logic [2:0] MODE_CHECKER = 3'd2;
  localparam logic [2:0] MODE_RANDOM  = 3'd3;
  localparam logic [2:0] MODE_INVERT  = 3'd4;
  localparam logic [7:0] LAST_ROW     = 8'(ARENA_HEIGHT - 1);

  // Handshake: a job is accepted on a rising edge where start=1 and ready=1;
  // start while ready=0 is dropped. done pulses for exactly one cycle per job.

  state_t      state;
  logic [2:0]  mode_q;
  logic [15:0] lfsr;
  logic [15:0] seed_eff;

  assign seed_eff  = (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
  assign state_dbg = state;

  function automatic logic [15:0] galois_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [ARENA_WIDTH-1:0] row_pattern(
    input logic [2:0]             m,
    input logic [7:0]             row,
    input logic [15:0]            lv,
    input logic [ARENA_WIDTH-1:0] cur
  );
    logic [ARENA_WIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < ARENA_WIDTH; i++) begin
      case (m)
        MODE_FILL:    p[i] = 1'b1;
        MODE_CHECKER: p[i] = (i[0] == row[0]);
        MODE_RANDOM:  p[i] = lv[i % 16];
        MODE_INVERT:  p[i] = ~cur[i];
        default:      p[i] = 1'b0;
      endcase
    end
    return p;
  endfunction

  // Outputs are computed for the state being entered, so write rises in the
  // first cycle after the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      mode_q              <= MODE_CLEAR;
      lfsr                <= LFSR_DEFAULT_SEED;
      ready               <= 1'b1;
      done                <= 1'b0;
      arena_row_select    <= 8'd0;
      arena_columns_new   <= '0;
      arena_columns_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready               <= 1'b1;
          done                <= 1'b0;
          arena_columns_write <= 1'b0;
          if (start && ready) begin
            mode_q           <= mode;
            ready            <= 1'b0;
            arena_row_select <= 8'd0;
            lfsr             <= seed_eff;
            if (mode == MODE_INVERT) begin
              state <= READ;
            end else if (mode <= MODE_RANDOM) begin
              state               <= WRITE;
              arena_columns_write <= 1'b1;
              arena_columns_new   <= row_pattern(mode, 8'd0, seed_eff, arena_columns_cur);
              lfsr                <= galois_step(seed_eff);
            end else begin
              state <= FINISH;
              done  <= 1'b1;
            end
          end
        end
        READ: begin
          state               <= WRITE;
          arena_columns_write <= 1'b1;
          arena_columns_new   <= row_pattern(mode_q, arena_row_select, lfsr, arena_columns_cur);
        end
        WRITE: begin
          if (arena_row_select == LAST_ROW) begin
            state               <= FINISH;
            arena_columns_write <= 1'b0;
            done                <= 1'b1;
          end else begin
            arena_row_select <= arena_row_select + 8'd1;
            if (mode_q == MODE_INVERT) begin
              state               <= READ;
              arena_columns_write <= 1'b0;
            end else begin
              arena_columns_write <= 1'b1;
              arena_columns_new   <= row_pattern(mode_q, arena_row_select + 8'd1, lfsr,
                                                 arena_columns_cur);
              lfsr                <= galois_step(lfsr);
            end
          end
        end
        FINISH: begin
          state               <= IDLE;
          done                <= 1'b0;
          ready               <= 1'b1;
          arena_columns_write <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arena_painter.sv
// Directed bench for arena_painter: a 10x10 arena model written through the row
// port, per-job write/done timing capture, and hand-computed row contents.
module tb_arena_painter;

  localparam int W = 10;
  localparam int H = 10;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   mode;
  logic [15:0]  seed;
  logic [W-1:0] arena_columns_cur;
  logic         ready;
  logic         done;
  logic [7:0]   arena_row_select;
  logic [W-1:0] arena_columns_new;
  logic         arena_columns_write;
  logic [1:0]   state_dbg;

  arena_painter #(.ARENA_WIDTH(W), .ARENA_HEIGHT(H), .LFSR_DEFAULT_SEED(16'hACE1)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .mode                (mode),
    .seed                (seed),
    .arena_columns_cur   (arena_columns_cur),
    .ready               (ready),
    .done                (done),
    .arena_row_select    (arena_row_select),
    .arena_columns_new   (arena_columns_new),
    .arena_columns_write (arena_columns_write),
    .state_dbg           (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // arena model: combinational read, write on rising edge, bench preload port
  logic [W-1:0] arena [0:H-1];
  logic         pre_we;
  logic [3:0]   pre_row;
  logic [W-1:0] pre_data;

  assign arena_columns_cur = (arena_row_select < 8'(H)) ? arena[arena_row_select[3:0]] : '0;

  always @(posedge clk) begin
    if (arena_columns_write && arena_row_select < 8'(H))
      arena[arena_row_select[3:0]] <= arena_columns_new;
    else if (pre_we)
      arena[pre_row] <= pre_data;
  end

  // scoreboard state
  int total = 0;
  int bad   = 0;
  int row_oob = 0;
  int nwr, done_cyc, extra_done, extra_wr;
  logic ready_after;
  int           wr_cyc  [0:31];
  logic [7:0]   wr_row  [0:31];
  logic [W-1:0] wr_data [0:31];
  logic [W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load_row(input int r, input logic [W-1:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_row = 4'(r); pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] v);
    logic [15:0] n;
    n = {1'b0, v[15:1]};
    if (v[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  // driver + monitor: cycle 1 is the cycle after the accept edge
  task automatic run_job(input logic [2:0] m, input logic [15:0] s, input bit poke);
    @(negedge clk);
    start = 1'b1; mode = m; seed = s;
    @(negedge clk);
    start = 1'b0;
    nwr = 0; done_cyc = 0; extra_done = 0; extra_wr = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (arena_row_select >= 8'(H)) row_oob++;
      if (arena_columns_write) begin
        if (nwr < 32) begin
          wr_cyc[nwr] = cyc; wr_row[nwr] = arena_row_select; wr_data[nwr] = arena_columns_new;
        end
        nwr++;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (poke) begin
        start = cyc[0];
        mode  = 3'($urandom_range(0, 7));
        seed  = 16'($urandom_range(0, 65535));
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (done_cyc == 0) check("job_timeout", 32'd0, 32'd1);
    @(negedge clk);
    ready_after = ready;
    repeat (3) begin
      if (done) extra_done++;
      if (arena_columns_write) extra_wr++;
      @(negedge clk);
    end
  endtask

  // rows ascending, each once; cycle k+1 (straight) or 2k+2 (invert)
  task automatic check_writes(input bit inv);
    check("write_count", 32'(nwr), 32'(H));
    for (int k = 0; k < H && k < nwr; k++) begin
      check($sformatf("row_order_%0d", k), 32'(wr_row[k]), 32'(k));
      check($sformatf("write_cycle_%0d", k), 32'(wr_cyc[k]), inv ? 32'(2*k+2) : 32'(k+1));
    end
    check("ready_after_done", 32'(ready_after), 32'd1);
    check("extra_done", 32'(extra_done), 32'd0);
    check("extra_write", 32'(extra_wr), 32'd0);
  endtask

  task automatic check_arena(input string tag);
    for (int r = 0; r < H; r++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check($sformatf("%s_row%0d", tag, r), 32'(arena[r]), 32'(e));
    end
  endtask

  task automatic check_random(input logic [15:0] s, input string tag);
    logic [15:0] v;
    v = (s == 16'h0) ? 16'hACE1 : s;
    for (int r = 0; r < H; r++) begin
      exp_q.push_back(v[W-1:0]);
      v = ref_step(v);
    end
    check_arena(tag);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 3'd0; seed = 16'h0; pre_we = 1'b0;
    pre_row = 4'd0; pre_data = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_write", 32'(arena_columns_write), 32'd0);
    check("rst_row", 32'(arena_row_select), 32'd0);
    check("rst_cols", 32'(arena_columns_new), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    rst_n = 1'b1;
    for (int r = 0; r < H; r++) load_row(r, '0);

    // FILL
    run_job(3'd1, 16'h0, 1'b0);
    check("fill_done_cyc", 32'(done_cyc), 32'd11);
    check_writes(1'b0);
    for (int k = 0; k < H; k++) check($sformatf("fill_data%0d", k), 32'(wr_data[k]), 32'h3FF);

    // CHECKER
    run_job(3'd2, 16'h0, 1'b0);
    check("chk_done_cyc", 32'(done_cyc), 32'd11);
    check_writes(1'b0);
    check("chk_row0", 32'(wr_data[0]), 32'h155);
    check("chk_row1", 32'(wr_data[1]), 32'h2AA);
    for (int r = 0; r < H; r++) exp_q.push_back(r[0] ? 10'h2AA : 10'h155);
    check_arena("chk_arena");

    // RANDOM
    run_job(3'd3, 16'h0000, 1'b0);
    check("rnd0_done_cyc", 32'(done_cyc), 32'd11);
    check("rnd0_row0", 32'(wr_data[0]), 32'h0E1);
    check("rnd0_row1", 32'(wr_data[1]), 32'h270);
    check_random(16'h0000, "rnd0_arena");
    run_job(3'd3, 16'h0001, 1'b0);
    check("rnd1_row0", 32'(wr_data[0]), 32'h001);
    check("rnd1_row1", 32'(wr_data[1]), 32'h000);
    check_random(16'h0001, "rnd1_arena");
    run_job(3'd3, 16'h1234, 1'b0);
    check_random(16'h1234, "rndA_arena");
    for (int r = 0; r < H; r++) load_row(r, '0);
    run_job(3'd3, 16'h1234, 1'b0);
    check_random(16'h1234, "rndB_arena");

    // INVERT over a glider
    for (int r = 0; r < H; r++) load_row(r, '0);
    load_row(1, 10'h004);
    load_row(2, 10'h008);
    load_row(3, 10'h00E);
    run_job(3'd4, 16'h0, 1'b0);
    check("inv_done_cyc", 32'(done_cyc), 32'd21);
    check_writes(1'b1);
    for (int r = 0; r < H; r++)
      exp_q.push_back(r == 1 ? 10'h3FB : r == 2 ? 10'h3F7 : r == 3 ? 10'h3F1 : 10'h3FF);
    check_arena("inv_arena");

    // start pokes and mode/seed churn mid-job
    run_job(3'd1, 16'h0, 1'b1);
    check("poke_done_cyc", 32'(done_cyc), 32'd11);
    check_writes(1'b0);
    for (int k = 0; k < H; k++) check($sformatf("poke_data%0d", k), 32'(wr_data[k]), 32'h3FF);

    // reserved mode
    run_job(3'd6, 16'h0, 1'b0);
    check("rsv_done_cyc", 32'(done_cyc), 32'd1);
    check("rsv_writes", 32'(nwr), 32'd0);
    check("rsv_ready_after", 32'(ready_after), 32'd1);

    // async reset during row 4 of FILL
    for (int r = 0; r < H; r++) load_row(r, '0);
    @(negedge clk);
    start = 1'b1; mode = 3'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("arst_pre_write", 32'(arena_columns_write), 32'd1);
    check("arst_pre_row", 32'(arena_row_select), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(ready), 32'd1);
    check("arst_done", 32'(done), 32'd0);
    check("arst_write", 32'(arena_columns_write), 32'd0);
    check("arst_row", 32'(arena_row_select), 32'd0);
    check("arst_cols", 32'(arena_columns_new), 32'd0);
    check("arst_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < H; r++) exp_q.push_back(r < 4 ? 10'h3FF : 10'h000);
    check_arena("arst_arena");
    run_job(3'd1, 16'h0, 1'b0);
    check("post_rst_done_cyc", 32'(done_cyc), 32'd11);
    check_writes(1'b0);

    check("row_select_range", 32'(row_oob), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
